// File: rtl/jsv_keycode_in.sv
// Keycode capture peripheral: synchronises a keyboard keycode, queues new key
// presses in a small FIFO and exposes them over an Avalon-MM slave with an irq.
module jsv_keycode_in #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [7:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int        PW         = $clog2(DEPTH);
  localparam logic [4:0] FULL_COUNT = 5'(DEPTH);

  logic [7:0]    s1, s2, last;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow, irq_en, cap_en;

  logic empty, full, push, pop, accept, drop, bus_write;

  // A push is a fresh non-zero keycode; last follows s2 even when capture is off.
  assign empty     = (count == 5'd0);
  assign full      = (count == FULL_COUNT);
  assign push      = cap_en && (s2 != last) && (s2 != 8'd0);
  assign pop       = chipselect && !read_n && (address == 2'd0) && !empty;
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign bus_write = chipselect && !write_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1       <= 8'd0;
      s2       <= 8'd0;
      last     <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      cap_en   <= 1'b0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      last <= s2;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)
        count <= count + 5'd1;
      else if (pop && !accept)
        count <= count - 5'd1;
      // Setting overflow takes priority over a software clear on the same edge.
      if (drop)
        overflow <= 1'b1;
      else if (bus_write && (address == 2'd1) && writedata[7])
        overflow <= 1'b0;
      if (bus_write && (address == 2'd2)) begin
        irq_en <= writedata[0];
        cap_en <= writedata[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept)
      mem[wr_ptr] <= s2;
  end

  always_comb begin
    readdata = 32'd0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata = empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]};
        2'd1:    readdata = {24'd0, overflow, full, empty, count};
        2'd2:    readdata = {30'd0, cap_en, irq_en};
        default: readdata = {24'd0, s2};
      endcase
    end
  end

  assign irq = irq_en && (!empty || overflow);

endmodule

// File: tb/tb_jsv_keycode_in.sv
// Directed bench for jsv_keycode_in: capture latency, FIFO ordering, overflow,
// simultaneous push/pop, live register and mid-operation reset.
module tb_jsv_keycode_in;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;

  jsv_keycode_in #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Combinational register peek: no strobe, no clock edge consumed.
  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    address    = a;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    #1;
    d = readdata;
    edges(1);
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    edges(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] key);
    in_port = key;
    edges(3);
  endtask

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = 32'd0; in_port = 8'h00;
    edges(2);
    reset = 1'b0;

    peek(2'd1, rd); checkOutput("reset_status", rd, 32'h20);
    peek(2'd2, rd); checkOutput("reset_ctrl", rd, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);

    // Capture latency: count rises exactly on the third edge.
    busWrite(2'd2, 32'h2);
    in_port = 8'h1C;
    edges(2);
    peek(2'd1, rd); checkOutput("latency_2edges", rd, 32'h20);
    edges(1);
    peek(2'd1, rd); checkOutput("latency_3edges", rd, 32'h01);
    busRead(2'd0, rd); checkOutput("data_1c", rd, 32'h11C);
    peek(2'd1, rd); checkOutput("after_pop_status", rd, 32'h20);

    busRead(2'd0, rd); checkOutput("empty_data", rd, 32'h0);
    peek(2'd1, rd); checkOutput("empty_pop_status", rd, 32'h20);

    // Capture disabled: live register still tracks, enabling does not push.
    busWrite(2'd2, 32'h0);
    applyStimulus(8'h5A);
    peek(2'd3, rd); checkOutput("live_5a", rd, 32'h5A);
    applyStimulus(8'h23);
    busWrite(2'd2, 32'h2);
    edges(3);
    peek(2'd1, rd); checkOutput("enable_no_push", rd, 32'h20);
    applyStimulus(8'h00);
    peek(2'd1, rd); checkOutput("release_no_push", rd, 32'h20);
    applyStimulus(8'h23);
    peek(2'd1, rd); checkOutput("repress_push", rd, 32'h01);
    busRead(2'd0, rd); checkOutput("data_23", rd, 32'h123);

    // Overflow: nine keys into an eight-deep FIFO.
    for (int k = 1; k <= 9; k++) applyStimulus(8'(k));
    peek(2'd1, rd); checkOutput("overflow_status", rd, 32'hC8);
    checkOutput("irq_disabled", {31'd0, irq}, 32'd0);
    busWrite(2'd2, 32'h3);
    checkOutput("irq_enabled", {31'd0, irq}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      busRead(2'd0, rd);
      checkOutput($sformatf("order_%0d", k), rd, 32'h100 | 32'(k));
    end
    peek(2'd1, rd); checkOutput("drained_status", rd, 32'hA0);
    checkOutput("irq_overflow_only", {31'd0, irq}, 32'd1);
    busWrite(2'd0, 32'hFF);
    busWrite(2'd1, 32'h80);
    peek(2'd1, rd); checkOutput("ovf_cleared", rd, 32'h20);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    peek(2'd2, rd); checkOutput("ctrl_kept", rd, 32'h3);

    // Full FIFO with a pop on the edge a push lands.
    for (int k = 8'h11; k <= 8'h18; k++) applyStimulus(8'(k));
    peek(2'd1, rd); checkOutput("full_status", rd, 32'h48);
    in_port = 8'h19;
    edges(2);
    busRead(2'd0, rd); checkOutput("pop_at_push", rd, 32'h111);
    peek(2'd1, rd); checkOutput("full_same_edge", rd, 32'h48);
    for (int k = 8'h12; k <= 8'h19; k++) begin
      busRead(2'd0, rd);
      checkOutput($sformatf("tail_%0h", k), rd, 32'h100 | 32'(k));
    end
    peek(2'd1, rd); checkOutput("tail_empty", rd, 32'h20);

    // Reset mid-push with a concurrent CTRL write that must be ignored.
    busWrite(2'd2, 32'h2);
    applyStimulus(8'h31);
    applyStimulus(8'h32);
    applyStimulus(8'h33);
    peek(2'd1, rd); checkOutput("count_3", rd, 32'h03);
    in_port = 8'h34;
    edges(2);
    reset = 1'b1;
    busWrite(2'd2, 32'h3);
    reset = 1'b0;
    peek(2'd1, rd); checkOutput("mid_reset_status", rd, 32'h20);
    peek(2'd2, rd); checkOutput("mid_reset_ctrl", rd, 32'h0);
    checkOutput("mid_reset_irq", {31'd0, irq}, 32'd0);
    edges(4);
    busWrite(2'd2, 32'h2);
    edges(3);
    peek(2'd1, rd); checkOutput("post_reset_no_push", rd, 32'h20);
    applyStimulus(8'h35);
    peek(2'd1, rd); checkOutput("post_reset_push", rd, 32'h01);
    busRead(2'd0, rd); checkOutput("data_35", rd, 32'h135);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
